// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive front-end.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVE   = 2'd1,
        WAIT_STOP = 2'd2
    } rx_state_t;

    localparam int RX_BLOCK_BITS = 128;

endpackage

// File: rtl/bus_sync_edge.sv
// Two-flop synchronisers plus history flop for scl/sda, with rising-edge,
// start and stop detection on the synchronised bus.
module bus_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_sync,
    output logic scl_rise,
    output logic start_det,
    output logic stop_det
);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3 (history)
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Synchroniser chains; reset loads an idle (high) bus so no false events fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda_sync  = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: gates the shift register, counts bits, flags
// malformed/dropped frames and hands completed blocks over with valid/ack.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter  int NUM_BITS = RX_BLOCK_BITS,
    localparam int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             block_ack,
    output logic             sda_sync,
    output logic             rising_edge_found,
    output logic             rx_enable,
    output logic             block_valid,
    output logic             frame_error,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

    logic scl_rise_s;
    logic start_s;
    logic stop_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             block_valid_q, block_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             overrun_q, overrun_d;

    bus_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_sync  (sda_sync),
        .scl_rise  (scl_rise_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    // Controller state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= CNT_ZERO;
            block_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            block_valid_q <= block_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic; bus start/stop always outrank bit counting.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        block_valid_d = block_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        // Ack clears first so a completion in the same cycle wins.
        if (block_ack && block_valid_q) begin
            block_valid_d = 1'b0;
        end else begin
            block_valid_d = block_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (start_s && block_valid_q) begin
                    overrun_d = 1'b1;
                end else if (start_s) begin
                    state_d   = RECEIVE;
                    bit_cnt_d = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            RECEIVE: begin
                if (stop_s) begin
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                    bit_cnt_d     = CNT_ZERO;
                end else if (start_s) begin
                    frame_error_d = 1'b1;
                    bit_cnt_d     = CNT_ZERO;
                end else if (scl_rise_s && (bit_cnt_q < CNT_MAX)) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d       = WAIT_STOP;
                        block_valid_d = 1'b1;
                    end else begin
                        state_d = RECEIVE;
                    end
                end else begin
                    state_d = RECEIVE;
                end
            end
            WAIT_STOP: begin
                if (stop_s) begin
                    state_d = IDLE;
                end else if (start_s) begin
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                end else if (scl_rise_s) begin
                    frame_error_d = 1'b1;
                end else begin
                    state_d = WAIT_STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = CNT_ZERO;
            end
        endcase
    end

    assign rising_edge_found = scl_rise_s;
    assign rx_enable         = (state_q == RECEIVE);
    assign block_valid       = block_valid_q;
    assign frame_error       = frame_error_q;
    assign overrun           = overrun_q;
    assign bit_cnt           = bit_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: a 128-bit and an 8-bit instance share the
// bus pins; a bit scoreboard checks every gated shift of the selected instance.
module tb_rx_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, scl, sda, ack;

    logic       sync_a, rise_a, rxen_a, bv_a, fe_a, ov_a;
    logic [7:0] cnt_a;
    logic       sync_b, rise_b, rxen_b, bv_b, fe_b, ov_b;
    logic [3:0] cnt_b;

    rx_frame_ctrl #(.NUM_BITS(128)) dut_a (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .block_ack(ack),
        .sda_sync(sync_a), .rising_edge_found(rise_a), .rx_enable(rxen_a),
        .block_valid(bv_a), .frame_error(fe_a), .overrun(ov_a), .bit_cnt(cnt_a)
    );

    rx_frame_ctrl #(.NUM_BITS(8)) dut_b (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .block_ack(ack),
        .sda_sync(sync_b), .rising_edge_found(rise_b), .rx_enable(rxen_b),
        .block_valid(bv_b), .frame_error(fe_b), .overrun(ov_b), .bit_cnt(cnt_b)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc_n = 0;
    int   fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, shift_cnt = 0, rxen_cnt = 0;
    int   last_rise_cyc = 0, bv_set_cyc = 0;
    logic bv_prev = 1'b0;
    bit   sel = 1'b0;          // 0: 128-bit instance, 1: 8-bit instance
    bit   exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample the selected instance at the falling edge.
    task automatic tick();
        logic r, e, s, b;
        @(negedge clk);
        cyc_n++;
        r = sel ? rise_b : rise_a;
        e = sel ? rxen_b : rxen_a;
        s = sel ? sync_b : sync_a;
        b = sel ? bv_b   : bv_a;
        if (sel ? fe_b : fe_a) fe_cnt++;
        if (sel ? ov_b : ov_a) ov_cnt++;
        if (e) rxen_cnt++;
        if (b && !bv_prev) bv_set_cyc = cyc_n;
        bv_prev = b;
        if (r) begin
            rise_cnt++;
            last_rise_cyc = cyc_n;
        end
        if (r && e) begin
            shift_cnt++;
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_bit", 32'(s), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Bits change sda while scl is low and leave scl high afterwards.
    task automatic send_bit(input logic b, input bit expect_shift);
        scl = 1'b0;
        ticks(3);
        sda = b;
        if (expect_shift) exp_q.push_back(b);
        ticks(3);
        scl = 1'b1;
        ticks(5);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit expect_shift);
        for (int i = 7; i >= 0; i--) send_bit(d[i], expect_shift);
    endtask

    task automatic send_start();
        sda = 1'b0;
        ticks(5);
    endtask

    // A stop after a trailing 1 needs sda low first, which costs one scl rise.
    task automatic send_stop();
        if (sda == 1'b1) begin
            scl = 1'b0;
            ticks(3);
            sda = 1'b0;
            ticks(3);
            scl = 1'b1;
            ticks(5);
        end
        sda = 1'b1;
        ticks(5);
    endtask

    task automatic do_reset();
        exp_q.delete();
        scl = 1'b1;
        sda = 1'b1;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sda_sync"}, 32'(sel ? sync_b : sync_a), 32'd1);
        chk({tag, "_rise"},     32'(sel ? rise_b : rise_a), 32'd0);
        chk({tag, "_rxen"},     32'(sel ? rxen_b : rxen_a), 32'd0);
        chk({tag, "_bv"},       32'(sel ? bv_b : bv_a),     32'd0);
        chk({tag, "_fe"},       32'(sel ? fe_b : fe_a),     32'd0);
        chk({tag, "_ov"},       32'(sel ? ov_b : ov_a),     32'd0);
        chk({tag, "_cnt"},      32'(sel ? {4'd0, cnt_b} : cnt_a), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rise, b_shift, b_fe, b_ov, b_rxen;
        logic rb;

        rst = 1'b1; scl = 1'b1; sda = 1'b1; ack = 1'b0;
        ticks(3);
        sel = 1'b0; chk_reset_outputs("rst_a");
        sel = 1'b1; chk_reset_outputs("rst_b");
        rst = 1'b0;
        ticks(2);

        // 1: full 128-bit frame of 0xA5
        sel = 1'b0;
        send_start();
        chk("t1_rxen_after_start", 32'(rxen_a), 32'd1);
        b_rise = rise_cnt; b_shift = shift_cnt; b_fe = fe_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
        chk("t1_rise_count",  32'(rise_cnt - b_rise), 32'd128);
        chk("t1_shift_count", 32'(shift_cnt - b_shift), 32'd128);
        chk("t1_bit_cnt",     32'(cnt_a), 32'd128);
        chk("t1_bv",          32'(bv_a), 32'd1);
        chk("t1_bv_latency",  32'(bv_set_cyc - last_rise_cyc), 32'd1);
        chk("t1_rxen_done",   32'(rxen_a), 32'd0);
        chk("t1_fe_none",     32'(fe_cnt - b_fe), 32'd0);
        chk("t1_sb_drained",  32'(exp_q.size()), 32'd0);
        send_stop();
        chk("t1_fe_stop_rise", 32'(fe_cnt - b_fe), 32'd1);
        chk("t1_cnt_after_stop", 32'(cnt_a), 32'd128);
        b_ov = ov_cnt;
        send_start();
        chk("t1_idle_overrun", 32'(ov_cnt - b_ov), 32'd1);
        chk("t1_idle_rxen",    32'(rxen_a), 32'd0);
        send_stop();

        // 2: short frame, 5 bits then stop
        do_reset();
        sel = 1'b1;
        b_fe = fe_cnt;
        send_start();
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
        chk("t2_cnt5", 32'(cnt_b), 32'd5);
        send_stop();
        chk("t2_fe",   32'(fe_cnt - b_fe), 32'd1);
        chk("t2_cnt0", 32'(cnt_b), 32'd0);
        chk("t2_bv",   32'(bv_b), 32'd0);
        chk("t2_rxen", 32'(rxen_b), 32'd0);

        // 3: repeated start after 3 bits, then full 8-bit frame
        do_reset();
        b_fe = fe_cnt;
        send_start();
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        chk("t3_cnt3", 32'(cnt_b), 32'd3);
        send_start();
        chk("t3_fe_restart", 32'(fe_cnt - b_fe), 32'd1);
        chk("t3_cnt_restart", 32'(cnt_b), 32'd0);
        chk("t3_rxen_restart", 32'(rxen_b), 32'd1);
        b_shift = shift_cnt;
        send_byte(8'hA4, 1'b1);
        chk("t3_shift8", 32'(shift_cnt - b_shift), 32'd8);
        chk("t3_cnt8",   32'(cnt_b), 32'd8);
        chk("t3_bv",     32'(bv_b), 32'd1);
        send_stop();
        chk("t3_fe_total", 32'(fe_cnt - b_fe), 32'd1);

        // 4: new frame while block still held, then ack
        b_ov = ov_cnt; b_rxen = rxen_cnt; b_fe = fe_cnt;
        send_start();
        send_byte(8'h5A, 1'b0);
        chk("t4_overrun",  32'(ov_cnt - b_ov), 32'd1);
        chk("t4_rxen_low", 32'(rxen_cnt - b_rxen), 32'd0);
        chk("t4_cnt_kept", 32'(cnt_b), 32'd8);
        chk("t4_bv_kept",  32'(bv_b), 32'd1);
        send_stop();
        chk("t4_fe_none",  32'(fe_cnt - b_fe), 32'd0);
        chk("t4_bv_pre_ack", 32'(bv_b), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t4_bv_acked", 32'(bv_b), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t4_ack_when_empty", 32'(bv_b), 32'd0);

        // 5: extra scl rise after a complete frame
        do_reset();
        send_start();
        send_byte(8'h3C, 1'b1);
        chk("t5_bv", 32'(bv_b), 32'd1);
        b_fe = fe_cnt;
        send_bit(1'b0, 1'b0);
        chk("t5_fe_9th",  32'(fe_cnt - b_fe), 32'd1);
        chk("t5_cnt_sat", 32'(cnt_b), 32'd8);
        chk("t5_rxen",    32'(rxen_b), 32'd0);
        send_stop();
        chk("t5_fe_after_stop", 32'(fe_cnt - b_fe), 32'd1);

        // 6: reset at bit 60 of a 128-bit frame, then a clean frame
        do_reset();
        sel = 1'b0;
        send_start();
        for (int i = 0; i < 59; i++) begin
            rb = 1'($urandom_range(0, 1));
            send_bit(rb, 1'b1);
        end
        send_bit(1'b1, 1'b1);
        chk("t6_cnt60", 32'(cnt_a), 32'd60);
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        exp_q.delete();
        ticks(3);
        send_start();
        chk("t6_rxen_restart", 32'(rxen_a), 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
        chk("t6_cnt128", 32'(cnt_a), 32'd128);
        chk("t6_bv",     32'(bv_a), 32'd1);
        chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);
        send_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Front-end controller for the serial receive path. Sits directly upstream of the 128-bit receive shift register.
- Synchronises the raw serial clock/data pins and detects bus start/stop conditions.
- Generates the shift strobe (rising_edge_found), the shift gate (rx_enable) and a synchronised data bit for the shift register.
- Counts received bits and hands a completed block to the downstream consumer with a valid/ack handshake.

Parameters:
- NUM_BITS, 128, bits per block; must equal the shift register width.
- CNT_W, $clog2(NUM_BITS+1), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- scl_in  in  1  raw serial clock pin (asynchronous)
- sda_in  in  1  raw serial data pin (asynchronous)
- block_ack  in  1  consumer has taken the block
- sda_sync  out  1  synchronised data bit; drives the shift register serial input
- rising_edge_found  out  1  one-cycle pulse on each synchronised scl 0->1
- rx_enable  out  1  shift gate; shift register shifts on rising_edge_found && rx_enable
- block_valid  out  1  a full NUM_BITS block is held in the shift register
- frame_error  out  1  one-cycle pulse on a malformed frame
- overrun  out  1  one-cycle pulse when a frame is dropped because block_valid=1
- bit_cnt  out  CNT_W  bits received in the current frame

Behaviour:
- Reset (rst sampled high at clk): all sync flops load 1 (idle bus). State=IDLE, bit_cnt=0, and every output is 0 except sda_sync=1.
- Synchroniser: scl and sda each pass through two flops (s1, s2), plus a history flop (s3).
  - sda_sync = sda_s2.
  - rising_edge_found = scl_s2 & ~scl_s3. It is high for exactly one cycle, 2 clk edges after the pin change.
- Start condition: scl_s2 & scl_s3 & sda_s3 & ~sda_s2.
- Stop condition: scl_s2 & scl_s3 & ~sda_s3 & sda_s2.
- States:
  - IDLE
    - On start with block_valid=0: go to RECEIVE, bit_cnt<=0.
    - On start with block_valid=1: overrun pulse; stay IDLE (frame ignored, held data preserved).
  - RECEIVE
    - rx_enable=1 combinationally.
    - On each rising_edge_found: bit_cnt++.
    - The edge that makes bit_cnt==NUM_BITS moves to WAIT_STOP and sets block_valid=1 on the next cycle.
    - Stop before NUM_BITS bits: frame_error pulse, go to IDLE, bit_cnt<=0. The partial register contents are don't-care.
    - Start (repeated start): frame_error pulse, stay in RECEIVE, bit_cnt<=0.
  - WAIT_STOP
    - rx_enable=0.
    - Stop: go to IDLE.
    - Any rising_edge_found: frame_error pulse, stay.
    - Start: frame_error pulse, go to IDLE; the next start is handled under the IDLE rules.
- Simultaneous start/stop with an edge: start/stop cannot coincide with rising_edge_found because both require scl_s3=1. Start/stop take priority over bit counting.
- block_valid handshake:
  - Set on completion; held until a cycle where block_ack=1, then cleared the next cycle.
  - block_ack while block_valid=0 is ignored.
  - Completion and ack in the same cycle: block_valid stays 1 (the new block wins).
- bit_cnt saturates at NUM_BITS and never wraps.
- rst asserted mid-frame: state returns to IDLE and the frame is abandoned. The first start after reset begins a fresh frame.

Decomposition:
- Shared package rx_pkg:
  - enum rx_state_t {IDLE, RECEIVE, WAIT_STOP} (2 bits).
  - Localparam RX_BLOCK_BITS = 128.
- Sub-module bus_sync_edge (2-flop sync + history flop + edge/start/stop detect), instantiated once with scl and sda.
- The controller FSM and counter live in rx_frame_ctrl.

Test Plan:
- Reset, then start followed by 128 clocked bits 0xA5 repeated, then stop: rx_enable high from start to the 128th edge; exactly 128 rising_edge_found pulses; bit_cnt=128; block_valid=1 one cycle after the last edge; state IDLE after stop.
- NUM_BITS=8, start, 5 bits, stop: frame_error one pulse; bit_cnt=0; block_valid=0.
- NUM_BITS=8, start, 3 bits, repeated start, 8 bits, stop: one frame_error; block_valid=1; exactly 8 counted edges after the restart.
- With block_valid=1 and no ack, send a new start plus 8 bits: overrun pulse; rx_enable stays 0; no bit_cnt change; block_valid stays 1. Then block_ack=1 for 1 cycle: block_valid=0 next cycle.
- Full frame, then a 9th scl rise before stop: frame_error pulse; bit_cnt stays 8 (NUM_BITS=8); rx_enable=0.
- Assert rst for 1 cycle at bit 60 of a 128-bit frame: all outputs return to reset values next cycle. A subsequent full frame completes normally with block_valid=1.
